// File: rtl/reg_uart_dump.sv
`default_nettype none
// ============================================================================
// Module      : reg_uart_dump
// Description : Snapshots CPU registers ax/bx/cx/dx on a debounced key press
//               and transmits "A=hh B=hh C=hh D=hh\r\n" over an 8N1 UART TX.
//               Optional macro REG_UART_DUMP_CHANGE_TRIG_EN also triggers a
//               dump whenever any of the four registers changes value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_uart_dump #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_dump_n,
    input  logic [7:0] ax,
    input  logic [7:0] bx,
    input  logic [7:0] cx,
    input  logic [7:0] dx,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int c_CLK_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_DB_CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CLK_CNT_W-1:0] c_CLK_LAST = c_CLK_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_DB_CNT_W-1:0]  c_DB_LAST  = c_DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] c_LAST_BYTE = 5'd20;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic                   r_key_meta;
    logic                   r_key_sync;
    logic                   r_key_db;
    logic                   r_key_db_d;
    logic [c_DB_CNT_W-1:0]  r_db_cnt;
    logic                   w_key_trig;
    logic                   w_trig;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [c_CLK_CNT_W-1:0] r_clk_cnt;
    logic [2:0]             r_bit_idx;
    logic [4:0]             r_byte_idx;
    logic                   r_pending;
    logic                   r_frame_done;
    logic [7:0]             r_snap_a;
    logic [7:0]             r_snap_b;
    logic [7:0]             r_snap_c;
    logic [7:0]             r_snap_d;
    logic [7:0]             w_tx_byte;
    logic                   w_bit_end;
    logic                   w_frame_end;
    logic                   w_restart;
    logic                   w_frame_start;

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        nib2asc = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Two-flop synchroniser for the asynchronous pushbutton
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
        end else begin
            r_key_meta <= key_dump_n;
            r_key_sync <= r_key_meta;
        end
    end

    // Debounce: accept a new level once it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_key_db_d <= r_key_db;
            if (r_key_sync == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_key_db <= r_key_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Press (debounced 1->0) only; release never triggers
    assign w_key_trig = r_key_db_d & ~r_key_db;

`ifdef REG_UART_DUMP_CHANGE_TRIG_EN
    logic [31:0] r_shadow;
    logic [31:0] w_regs;
    assign w_regs = {ax, bx, cx, dx};

    // Shadow copy tracks the live registers so any change yields one trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            r_shadow <= w_regs;
        end
    end

    assign w_trig = w_key_trig | (w_regs != r_shadow);
`else
    assign w_trig = w_key_trig;
`endif

    assign w_bit_end     = (r_clk_cnt == c_CLK_LAST);
    assign w_frame_end   = (r_state == c_ST_STOP) && w_bit_end && (r_byte_idx == c_LAST_BYTE);
    assign w_restart     = w_frame_end && (r_pending || w_trig);
    assign w_frame_start = ((r_state == c_ST_IDLE) && w_trig) || w_restart;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; STOP chains straight into the next START
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_trig) w_state_next = c_ST_START;
            c_ST_START: if (w_bit_end) w_state_next = c_ST_DATA;
            c_ST_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = c_ST_STOP;
            c_ST_STOP: begin
                if (w_bit_end) begin
                    if ((r_byte_idx != c_LAST_BYTE) || w_restart) begin
                        w_state_next = c_ST_START;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Bit/byte timing counters, one-deep pending flag, snapshot and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_snap_a     <= '0;
            r_snap_b     <= '0;
            r_snap_c     <= '0;
            r_snap_d     <= '0;
        end else begin
            r_frame_done <= w_frame_end;

            if ((r_state == c_ST_IDLE) || w_bit_end) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (r_state != c_ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if ((r_state == c_ST_IDLE) || w_frame_end) begin
                r_byte_idx <= '0;
            end else if ((r_state == c_ST_STOP) && w_bit_end) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end

            // A trigger on the final stop cycle is consumed by the restart itself
            if (w_frame_end) begin
                r_pending <= 1'b0;
            end else if ((r_state != c_ST_IDLE) && w_trig) begin
                r_pending <= 1'b1;
            end

            if (w_frame_start) begin
                r_snap_a <= ax;
                r_snap_b <= bx;
                r_snap_c <= cx;
                r_snap_d <= dx;
            end
        end
    end

    // Character selection for the current byte index
    always_comb begin
        w_tx_byte = 8'h0A;
        case (r_byte_idx)
            5'd0:    w_tx_byte = 8'h41;
            5'd1:    w_tx_byte = 8'h3D;
            5'd2:    w_tx_byte = nib2asc(r_snap_a[7:4]);
            5'd3:    w_tx_byte = nib2asc(r_snap_a[3:0]);
            5'd4:    w_tx_byte = 8'h20;
            5'd5:    w_tx_byte = 8'h42;
            5'd6:    w_tx_byte = 8'h3D;
            5'd7:    w_tx_byte = nib2asc(r_snap_b[7:4]);
            5'd8:    w_tx_byte = nib2asc(r_snap_b[3:0]);
            5'd9:    w_tx_byte = 8'h20;
            5'd10:   w_tx_byte = 8'h43;
            5'd11:   w_tx_byte = 8'h3D;
            5'd12:   w_tx_byte = nib2asc(r_snap_c[7:4]);
            5'd13:   w_tx_byte = nib2asc(r_snap_c[3:0]);
            5'd14:   w_tx_byte = 8'h20;
            5'd15:   w_tx_byte = 8'h44;
            5'd16:   w_tx_byte = 8'h3D;
            5'd17:   w_tx_byte = nib2asc(r_snap_d[7:4]);
            5'd18:   w_tx_byte = nib2asc(r_snap_d[3:0]);
            5'd19:   w_tx_byte = 8'h0D;
            default: w_tx_byte = 8'h0A;
        endcase
    end

    // FSM outputs; reset forces IDLE so the line returns high asynchronously
    always_comb begin
        uart_tx = 1'b1;
        busy    = 1'b0;
        case (r_state)
            c_ST_START: begin
                uart_tx = 1'b0;
                busy    = 1'b1;
            end
            c_ST_DATA: begin
                uart_tx = w_tx_byte[r_bit_idx];
                busy    = 1'b1;
            end
            c_ST_STOP: begin
                uart_tx = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                uart_tx = 1'b1;
                busy    = 1'b0;
            end
        endcase
    end

    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_uart_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_uart_dump
// Description : Scoreboard bench for reg_uart_dump (CLKS_PER_BIT=4,
//               DEBOUNCE_CYCLES=8). Stimulus pushes hand-written expected
//               lines; a UART monitor decodes uart_tx and pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_uart_dump;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_dump_n = 1'b1;
    logic [7:0] ax = '0;
    logic [7:0] bx = '0;
    logic [7:0] cx = '0;
    logic [7:0] dx = '0;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;

    reg_uart_dump #(.CLKS_PER_BIT(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .key_dump_n(key_dump_n),
        .ax(ax), .bx(bx), .cx(cx), .dx(dx),
        .uart_tx(uart_tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int bytes_seen = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic press();
        key_dump_n = 1'b0;
        repeat (20) @(negedge clk);
        key_dump_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_fd(input int bound, output int found, output int at_cyc);
        found = 0;
        at_cyc = 0;
        for (int i = 0; i < bound && found == 0; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1;
                at_cyc = cyc;
            end
        end
    endtask

    task automatic wait_bytes(input int target, input int bound, output int found);
        found = 0;
        for (int i = 0; i < bound && found == 0; i++) begin
            @(negedge clk);
            if (bytes_seen >= target) found = 1;
        end
    endtask

    // UART receiver: samples each bit at its second clock of four
    initial begin : monitor
        logic [7:0] rx;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                aborted = 1'b0;
                rx = '0;
                @(negedge clk);
                if (rst_n !== 1'b1 || uart_tx !== 1'b0) aborted = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    repeat (4) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                    end
                    rx[b] = uart_tx;
                end
                repeat (4) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1'b1;
                end
                if (!aborted) begin
                    bytes_seen++;
                    check("stop_bit", {31'd0, uart_tx}, 32'd1);
                    if (exp_q.size() == 0) check("unexpected_byte", {24'd0, rx}, 32'h100);
                    else check("rx_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #(20000 * 10);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int found, t0, t1, t2, base, fd0, lat, tx_bad, busy_bad, seen;
        repeat (5) @(negedge clk);
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;

        // Idle for 1000 cycles with no key
        tx_bad = 0; busy_bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) tx_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        check("idle_tx_low_cycles", tx_bad, 0);
        check("idle_busy_cycles", busy_bad, 0);

`ifdef REG_UART_DUMP_CHANGE_TRIG_EN
        // Register change triggers a dump; two changes mid-frame give one more
        fd0 = fd_cnt;
        push_line("A=00 B=00 C=00 D=07");
        dx = 8'h07;
        repeat (100) @(negedge clk);
        check("chg_busy", {31'd0, busy}, 32'd1);
        cx = 8'h10;
        repeat (100) @(negedge clk);
        cx = 8'h5C;
        push_line("A=00 B=00 C=5C D=07");
        wait_fd(900, found, t1);
        check("chg_fd1_found", found, 1);
        wait_fd(900, found, t2);
        check("chg_fd2_found", found, 1);
        check("chg_fd_spacing", t2 - t1, 840);
        repeat (900) @(negedge clk);
        check("chg_fd_total", fd_cnt - fd0, 2);
        check("chg_queue_empty", exp_q.size(), 0);
`else
        // Single press: latency, content and frame length
        ax = 8'h3F; bx = 8'h00; cx = 8'hA5; dx = 8'hFF;
        push_line("A=3F B=00 C=A5 D=FF");
        @(negedge clk);
        t0 = cyc; seen = 0; t1 = 0; tx_bad = 0;
        key_dump_n = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!seen && busy === 1'b1) begin
                seen = 1;
                t1 = cyc;
                if (uart_tx !== 1'b0) tx_bad = 1;
            end
        end
        key_dump_n = 1'b1;
        lat = t1 - t0;
        check("busy_seen", seen, 1);
        check("busy_within_12", {31'd0, (lat > 0 && lat <= 12)}, 32'd1);
        check("tx_low_with_busy", tx_bad, 0);
        wait_fd(900, found, t2);
        check("fd1_found", found, 1);
        check("frame_len", t2 - t1, 840);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        check("queue_empty_1", exp_q.size(), 0);

        // Short glitches must never trigger
        base = bytes_seen; busy_bad = 0;
        repeat (3) begin
            key_dump_n = 1'b0;
            repeat (5) begin @(negedge clk); if (busy !== 1'b0) busy_bad++; end
            key_dump_n = 1'b1;
            repeat (10) begin @(negedge clk); if (busy !== 1'b0) busy_bad++; end
        end
        repeat (30) begin @(negedge clk); if (busy !== 1'b0) busy_bad++; end
        check("glitch_busy_cycles", busy_bad, 0);
        check("glitch_no_bytes", bytes_seen - base, 0);

        // Three presses: second pends, third is dropped; frames back to back
        ax = 8'h12; bx = 8'h34; cx = 8'h9C; dx = 8'hE0;
        push_line("A=12 B=34 C=9C D=E0");
        push_line("A=12 B=34 C=9C D=E0");
        fd0 = fd_cnt;
        press();
        press();
        press();
        wait_fd(900, found, t1);
        check("b2b_fd1_found", found, 1);
        check("b2b_busy_at_fd1", {31'd0, busy}, 32'd1);
        check("b2b_tx_start_at_fd1", {31'd0, uart_tx}, 32'd0);
        wait_fd(900, found, t2);
        check("b2b_fd2_found", found, 1);
        check("b2b_fd_spacing", t2 - t1, 840);
        repeat (900) @(negedge clk);
        check("b2b_fd_total", fd_cnt - fd0, 2);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Snapshot isolation, then reset mid-frame
        ax = 8'h11; bx = 8'hB7; cx = 8'h4D; dx = 8'h08;
        push_line("A=11 B=B7 C=4D D=08");
        base = bytes_seen;
        press();
        wait_bytes(base + 5, 400, found);
        check("snap_reach_byte5", found, 1);
        ax = 8'h22;
        wait_bytes(base + 10, 400, found);
        check("snap_reach_byte10", found, 1);
        repeat (8) @(negedge clk);
        fd0 = fd_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_high", {31'd0, uart_tx}, 32'd1);
        check("rst_busy_low", {31'd0, busy}, 32'd0);
        check("rst_frame_done_low", {31'd0, frame_done}, 32'd0);
        check("rst_bytes_left", exp_q.size(), 11);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_no_frame_done", fd_cnt - fd0, 0);
        check("rst_idle_busy", {31'd0, busy}, 32'd0);
        push_line("A=22 B=B7 C=4D D=08");
        press();
        wait_fd(900, found, t1);
        check("post_rst_fd_found", found, 1);
        check("post_rst_queue_empty", exp_q.size(), 0);
`endif
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_uart_dump.md
Name: reg_uart_dump

Overview:
- Downstream consumer of the CPU top-level register outputs ax, bx, cx, dx. It sits beside the LED and VGA display paths.
- On a debounced button press it snapshots all four registers and transmits one ASCII line over a UART TX pin (8N1, LSB first).
- Line format: "A=hh B=hh C=hh D=hh\r\n", 21 bytes, hex digits uppercase.
- Gives a host-side register trace without ChipScope.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised key must hold a level before it is accepted (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- key_dump_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- ax  input  8  register A value.
- bx  input  8  register B value.
- cx  input  8  register C value.
- dx  input  8  register D value.
- uart_tx  output  1  serial data; idle high.
- busy  output  1  high from frame start until the last stop bit completes.
- frame_done  output  1  one-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset values: uart_tx=1, busy=0, frame_done=0, FSM=IDLE, pending=0, debounced key=released (1), all counters=0.
- Key synchroniser and debounce:
  - key_dump_n passes through a 2-flop synchroniser.
  - A counter increments while the synchronised value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A 1->0 transition of the debounced level raises a one-cycle trigger.
- Trigger handling:
  - Trigger in IDLE starts a frame on the next cycle.
  - Trigger while busy sets pending. pending is one-deep; extra triggers while pending=1 are dropped.
  - At frame end, if pending=1: clear it and start a new frame immediately. busy stays high and frame_done still pulses.
- Snapshot: ax, bx, cx, dx are captured in one cycle on the IDLE->START transition. Register changes during a frame do not affect that frame.
- Byte sequence, indices 0..20: 'A','=',hiA,loA,' ','B','=',hiB,loB,' ','C','=',hiC,loC,' ','D','=',hiD,loD,0x0D,0x0A.
  - Nibble to ASCII: 0-9 -> 0x30+n; A-F -> 0x37+n.
- FSM states: IDLE, START, DATA, STOP.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - After STOP: if byte index < 20, increment the index and go to START with no idle gap. Otherwise the frame ends.
- Frame timing:
  - Frame length = 21*10*CLKS_PER_BIT cycles from the start-bit edge to the end of the last stop bit.
  - busy rises in the same cycle uart_tx first drops.
  - busy falls and frame_done pulses in the cycle after the last stop bit completes, unless pending restarts the frame.
- Reset mid-frame: uart_tx returns high asynchronously, the frame is abandoned, pending clears, and no frame_done is issued.
- Key bounce shorter than DEBOUNCE_CYCLES produces no trigger. The release edge never triggers.

Optional Feature:
- Macro: REG_UART_DUMP_CHANGE_TRIG_EN.
- When defined:
  - A shadow copy of {ax,bx,cx,dx}, reset to 0, is compared every cycle.
  - Any difference raises a trigger (same rules as a key trigger) and updates the shadow.
  - A change while busy sets pending, so the final value is always dumped.
- When undefined: no shadow logic; only the key triggers frames.

Test Plan (CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8):
- Reset, no key -> uart_tx=1, busy=0 for 1000 cycles.
- ax=0x3F, bx=0x00, cx=0xA5, dx=0xFF; hold key low for 20 cycles -> busy high within 12 cycles of press; decoded bytes "A=3F B=00 C=A5 D=FF\r\n"; frame_done pulse exactly 840 cycles after the start-bit edge.
- Key glitches low for 5 cycles, three times -> no start bit, busy stays 0.
- Two presses, the second during a frame, then a third during that same frame -> exactly two back-to-back frames; no idle high gap between the stop bit and the next start bit; frame_done pulses twice.
- Change ax from 0x11 to 0x22 at byte 5 of a frame -> that frame still sends "A=11"; then assert rst_n=0 at byte 10 -> uart_tx=1 immediately, busy=0, no frame_done, and the next press sends a full frame with "A=22".
- With REG_UART_DUMP_CHANGE_TRIG_EN: write dx=0x07, no key -> one frame ending "D=07\r\n"; write cx twice during that frame -> exactly one further frame carrying the final cx.
